// File: rtl/fpdiv_pkg.sv
// Shared definitions for the fpdiv controller and datapath.
package fpdiv_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRE_N  = 3'd1,
    S_PRE_D  = 3'd2,
    S_ITER_N = 3'd3,
    S_ITER_D = 3'd4,
    S_REM    = 3'd5,
    S_CAPT   = 3'd6
  } fpdiv_state_t;

  // Multiplier-A operand select
  localparam logic [1:0] MUX4_NUM  = 2'b00;
  localparam logic [1:0] MUX4_DEN  = 2'b01;
  localparam logic [1:0] MUX4_REGA = 2'b10;
  localparam logic [1:0] MUX4_REGB = 2'b11;

  // Multiplier-B operand select
  localparam logic [1:0] MUX3_IA  = 2'b00;
  localparam logic [1:0] MUX3_C   = 2'b01;
  localparam logic [1:0] MUX3_REM = 2'b10;

endpackage

// File: rtl/fpdiv_ctrl.sv
// Sequencer for the Goldschmidt fpdiv datapath: start/busy/done handshake,
// operand latching, mux/enable decode per phase and result capture.
module fpdiv_ctrl
  import fpdiv_pkg::*;
#(
  parameter int unsigned ITERS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] num_in,
  input  logic [31:0] den_in,
  input  logic        rm_in,
  input  logic [31:0] final_ans,
  output logic [31:0] op_num,
  output logic [31:0] op_den,
  output logic        rm,
  output logic [1:0]  sel_mux3,
  output logic [1:0]  sel_mux4,
  output logic        en_a,
  output logic        en_b,
  output logic        en_rem,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned CW = $clog2(ITERS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(ITERS - 1);

  fpdiv_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   op_num_q, op_num_d;
  logic [31:0]   op_den_q, op_den_d;
  logic          rm_q, rm_d;
  logic [31:0]   result_q, result_d;
  logic          done_q, done_d;
  logic [1:0]    sel_mux3_q, sel_mux3_d;
  logic [1:0]    sel_mux4_q, sel_mux4_d;
  logic          en_a_q, en_a_d;
  logic          en_b_q, en_b_d;
  logic          en_rem_q, en_rem_d;
  logic          busy_q, busy_d;

  // Next-state, iteration counter, operand latches and result capture
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_num_d = op_num_q;
    op_den_d = op_den_q;
    rm_d     = rm_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_num_d = num_in;
          op_den_d = den_in;
          rm_d     = rm_in;
          cnt_d    = '0;
          state_d  = S_PRE_N;
        end
      end
      S_PRE_N:  state_d = S_PRE_D;
      S_PRE_D:  state_d = S_ITER_N;
      S_ITER_N: state_d = S_ITER_D;
      S_ITER_D: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == LAST_CNT) ? S_REM : S_ITER_N;
      end
      S_REM:    state_d = S_CAPT;
      S_CAPT: begin
        result_d = final_ans;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore decode evaluated on the next state so the registered outputs
  // line up with the state they belong to
  always_comb begin
    sel_mux4_d = MUX4_NUM;
    sel_mux3_d = MUX3_IA;
    en_a_d     = 1'b0;
    en_b_d     = 1'b0;
    en_rem_d   = 1'b0;
    busy_d     = (state_d != S_IDLE);
    case (state_d)
      S_PRE_N: begin
        sel_mux4_d = MUX4_NUM;
        sel_mux3_d = MUX3_IA;
        en_a_d     = 1'b1;
      end
      S_PRE_D: begin
        sel_mux4_d = MUX4_DEN;
        sel_mux3_d = MUX3_IA;
        en_b_d     = 1'b1;
      end
      S_ITER_N: begin
        sel_mux4_d = MUX4_REGA;
        sel_mux3_d = MUX3_C;
        en_a_d     = 1'b1;
      end
      S_ITER_D: begin
        sel_mux4_d = MUX4_REGB;
        sel_mux3_d = MUX3_C;
        en_b_d     = 1'b1;
      end
      S_REM: begin
        sel_mux4_d = MUX4_REGA;
        sel_mux3_d = MUX3_REM;
        en_rem_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // State, latches and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_num_q   <= '0;
      op_den_q   <= '0;
      rm_q       <= 1'b0;
      result_q   <= '0;
      done_q     <= 1'b0;
      sel_mux3_q <= '0;
      sel_mux4_q <= '0;
      en_a_q     <= 1'b0;
      en_b_q     <= 1'b0;
      en_rem_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_num_q   <= op_num_d;
      op_den_q   <= op_den_d;
      rm_q       <= rm_d;
      result_q   <= result_d;
      done_q     <= done_d;
      sel_mux3_q <= sel_mux3_d;
      sel_mux4_q <= sel_mux4_d;
      en_a_q     <= en_a_d;
      en_b_q     <= en_b_d;
      en_rem_q   <= en_rem_d;
      busy_q     <= busy_d;
    end
  end

  assign op_num   = op_num_q;
  assign op_den   = op_den_q;
  assign rm       = rm_q;
  assign result   = result_q;
  assign done     = done_q;
  assign sel_mux3 = sel_mux3_q;
  assign sel_mux4 = sel_mux4_q;
  assign en_a     = en_a_q;
  assign en_b     = en_b_q;
  assign en_rem   = en_rem_q;
  assign busy     = busy_q;

endmodule
